// File: rtl/tlul_master_ch_pkg.sv
// tlul_master_ch_pkg: TL-UL opcode constants and width helpers
package tlul_master_ch_pkg;
  localparam logic [2:0] A_PUTFULL = 3'd0;
  localparam logic [2:0] A_PUTPART = 3'd1;
  localparam logic [2:0] A_GET     = 3'd4;
  localparam logic [2:0] D_ACK     = 3'd0;
  localparam logic [2:0] D_ACKDATA = 3'd1;
  function automatic logic [1:0] size_of(int dw);
    return 2'($clog2(dw / 8));
  endfunction
  function automatic int src_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tlul_master_ch_if.sv
// tlul_master_ch_if: command, TL-UL A/D channel and response bundle
interface tlul_master_ch_if #(parameter int AW = 32, parameter int DW = 32, parameter int NSRC = 4);
  localparam int MW = DW / 8;
  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [MW-1:0] cmd_mask;
  logic          a_valid, a_ready;
  logic [2:0]    a_opcode, a_param;
  logic [1:0]    a_size;
  logic [SW-1:0] a_source;
  logic [AW-1:0] a_address;
  logic [MW-1:0] a_mask;
  logic [DW-1:0] a_data;
  logic          d_valid, d_ready, d_error;
  logic [2:0]    d_opcode;
  logic [SW-1:0] d_source;
  logic [DW-1:0] d_data;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [SW-1:0] rsp_id;
  logic [DW-1:0] rsp_rdata;
  logic          busy, unexp;
  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_mask, a_ready,
           d_valid, d_opcode, d_source, d_data, d_error, rsp_ready,
    output cmd_ready, a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
           d_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, busy, unexp
  );
  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_mask, a_ready,
           d_valid, d_opcode, d_source, d_data, d_error, rsp_ready,
    input  cmd_ready, a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
           d_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, busy, unexp
  );
endinterface

// File: rtl/tlul_master_ch_source_alloc.sv
// tlul_master_ch_source_alloc: outstanding-source bitmap with lowest-free allocation
module tlul_master_ch_source_alloc #(parameter int NSRC = 4, parameter int SW = 2) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc,
  input  logic          alloc_we,
  output logic [SW-1:0] alloc_id,
  input  logic          free,
  input  logic [SW-1:0] free_id,
  output logic          hit,
  output logic          hit_we,
  output logic          full,
  output logic          busy
);
  logic [NSRC-1:0] bmp, we;
  assign full = &bmp;
  assign busy = |bmp;
  // free_id may exceed NSRC-1 when NSRC is 1, so lookup scans rather than indexes
  always_comb begin
    alloc_id = '0;
    hit = 1'b0;
    hit_we = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) if (!bmp[i]) alloc_id = SW'(i);
    for (int i = 0; i < NSRC; i++) if (free_id == SW'(i)) {hit, hit_we} = {bmp[i], we[i]};
  end
  always_ff @(posedge clk)
    if (rst) begin
      bmp <= '0;
      we <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (alloc && alloc_id == SW'(i)) begin
          bmp[i] <= 1'b1;
          we[i] <= alloc_we;
        end else if (free && free_id == SW'(i)) bmp[i] <= 1'b0;
      end
    end
endmodule

// File: rtl/tlul_master_ch.sv
// tlul_master_ch: TL-UL master issuing Get/PutFull/PutPartial and returning tagged D responses
module tlul_master_ch
  import tlul_master_ch_pkg::*;
#(parameter int AW = 32, parameter int DW = 32, parameter int NSRC = 4) (
  input logic clk,
  input logic rst,
  tlul_master_ch_if.master bus
);
  localparam int MW = DW / 8;
  localparam int SW = src_w(NSRC);
  logic          cmd_ready, cmd_hs, d_ready, d_hs, hit, hit_we, full, busy;
  logic [SW-1:0] alloc_id;
  logic          a_valid, rsp_valid, rsp_err, unexp;
  logic [2:0]    a_opcode;
  logic [1:0]    a_size;
  logic [SW-1:0] a_source, rsp_id;
  logic [AW-1:0] a_address;
  logic [MW-1:0] a_mask;
  logic [DW-1:0] a_data, rsp_rdata;
  assign cmd_ready = (!a_valid | bus.a_ready) & !full;
  assign cmd_hs = bus.cmd_valid & cmd_ready;
  assign d_ready = !rsp_valid | bus.rsp_ready;
  assign d_hs = bus.d_valid & d_ready;
  tlul_master_ch_source_alloc #(.NSRC(NSRC), .SW(SW)) u_alloc (
    .clk(clk), .rst(rst),
    .alloc(cmd_hs), .alloc_we(bus.cmd_we), .alloc_id(alloc_id),
    .free(d_hs & hit), .free_id(bus.d_source), .hit(hit), .hit_we(hit_we),
    .full(full), .busy(busy)
  );
  always_ff @(posedge clk)
    if (rst) begin
      a_valid <= 1'b0;
      a_opcode <= '0;
      a_size <= '0;
      a_source <= '0;
      a_address <= '0;
      a_mask <= '0;
      a_data <= '0;
    end else if (cmd_hs) begin
      a_valid <= 1'b1;
      a_opcode <= !bus.cmd_we ? A_GET : &bus.cmd_mask ? A_PUTFULL : A_PUTPART;
      a_size <= size_of(DW);
      a_source <= alloc_id;
      a_address <= bus.cmd_addr;
      a_mask <= bus.cmd_we ? bus.cmd_mask : '1;
      a_data <= bus.cmd_we ? bus.cmd_wdata : '0;
    end else if (bus.a_ready) a_valid <= 1'b0;
  // beats for sources not outstanding are swallowed and only flagged
  always_ff @(posedge clk)
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      unexp <= 1'b0;
    end else begin
      if (d_hs && hit) begin
        rsp_valid <= 1'b1;
        rsp_id <= bus.d_source;
        rsp_rdata <= hit_we ? '0 : bus.d_data;
        rsp_err <= bus.d_error | (hit_we ? bus.d_opcode != D_ACK : bus.d_opcode != D_ACKDATA);
      end else if (bus.rsp_ready) rsp_valid <= 1'b0;
      if (d_hs && !hit) unexp <= 1'b1;
    end
  assign bus.cmd_ready = cmd_ready;
  assign bus.d_ready = d_ready;
  assign bus.a_valid = a_valid;
  assign bus.a_opcode = a_opcode;
  assign bus.a_param = 3'd0;
  assign bus.a_size = a_size;
  assign bus.a_source = a_source;
  assign bus.a_address = a_address;
  assign bus.a_mask = a_mask;
  assign bus.a_data = a_data;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id = rsp_id;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err = rsp_err;
  assign bus.busy = busy;
  assign bus.unexp = unexp;
endmodule

// File: tb/tb_tlul_master_ch.sv
// tb_tlul_master_ch: directed and randomized checks against a transaction-level model
module tb_tlul_master_ch;
  localparam int AW = 32, DW = 32, NSRC = 4, SW = 2, MW = 4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  tlul_master_ch_if #(.AW(AW), .DW(DW), .NSRC(NSRC)) bus ();
  tlul_master_ch #(.AW(AW), .DW(DW), .NSRC(NSRC)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0;
  bit [NSRC-1:0] m_out, m_we;
  bit            m_av, m_rv, m_re, m_unexp;
  bit [2:0]      m_op;
  bit [SW-1:0]   m_src, m_rid;
  bit [AW-1:0]   m_addr;
  bit [MW-1:0]   m_mask;
  bit [DW-1:0]   m_data, m_rd;
  int            pend[$];
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic idle();
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_we = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_wdata = '0;
    bus.cmd_mask = '0;
    bus.a_ready = 1'b1;
    bus.d_valid = 1'b0;
    bus.d_opcode = '0;
    bus.d_source = '0;
    bus.d_data = '0;
    bus.d_error = 1'b0;
    bus.rsp_ready = 1'b1;
  endtask
  // one clock: compare outputs to model, then advance model by the handshakes of this cycle
  task automatic cycle();
    bit cr, dr, hc, ha, hd, hit;
    int fid, s, idx;
    #1;
    cr = (!m_av || bus.a_ready) && (m_out != '1);
    dr = !m_rv || bus.rsp_ready;
    chk("cmd_ready", 64'(bus.cmd_ready), 64'(cr));
    chk("d_ready", 64'(bus.d_ready), 64'(dr));
    chk("a_valid", 64'(bus.a_valid), 64'(m_av));
    if (m_av) begin
      chk("a_opcode", 64'(bus.a_opcode), 64'(m_op));
      chk("a_param", 64'(bus.a_param), 64'(0));
      chk("a_size", 64'(bus.a_size), 64'(2));
      chk("a_source", 64'(bus.a_source), 64'(m_src));
      chk("a_address", 64'(bus.a_address), 64'(m_addr));
      chk("a_mask", 64'(bus.a_mask), 64'(m_mask));
      chk("a_data", 64'(bus.a_data), 64'(m_data));
    end
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_rv));
    if (m_rv) begin
      chk("rsp_id", 64'(bus.rsp_id), 64'(m_rid));
      chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(m_rd));
      chk("rsp_err", 64'(bus.rsp_err), 64'(m_re));
    end
    chk("busy", 64'(bus.busy), 64'(m_out != '0));
    chk("unexp", 64'(bus.unexp), 64'(m_unexp));
    fid = 0;
    for (int i = NSRC - 1; i >= 0; i--) if (!m_out[i]) fid = i;
    hc = bus.cmd_valid && cr;
    ha = m_av && bus.a_ready;
    hd = bus.d_valid && dr;
    s = int'(bus.d_source);
    hit = m_out[s];
    @(posedge clk);
    if (rst) begin
      m_out = '0; m_we = '0; m_av = 0; m_rv = 0; m_re = 0; m_unexp = 0;
      pend.delete();
    end else begin
      if (ha) pend.push_back(int'(m_src));
      if (hc) begin
        m_av = 1;
        m_op = !bus.cmd_we ? 3'd4 : (bus.cmd_mask == 4'hF) ? 3'd0 : 3'd1;
        m_src = SW'(fid);
        m_addr = bus.cmd_addr;
        m_mask = bus.cmd_we ? bus.cmd_mask : 4'hF;
        m_data = bus.cmd_we ? bus.cmd_wdata : '0;
        m_we[fid] = bus.cmd_we;
      end else if (ha) m_av = 0;
      if (hd && hit) begin
        m_rv = 1;
        m_rid = SW'(s);
        m_rd = m_we[s] ? '0 : bus.d_data;
        m_re = bus.d_error || (m_we[s] ? bus.d_opcode != 3'd0 : bus.d_opcode != 3'd1);
        m_out[s] = 0;
        idx = -1;
        for (int k = 0; k < pend.size(); k++) if (pend[k] == s && idx < 0) idx = k;
        if (idx >= 0) pend.delete(idx);
      end else begin
        if (hd) m_unexp = 1;
        if (bus.rsp_ready) m_rv = 0;
      end
      if (hc) m_out[fid] = 1;
    end
    @(negedge clk);
  endtask
  task automatic txn(input bit we, input logic [31:0] addr, input logic [3:0] mask,
                     input logic [2:0] exp_op, input logic [2:0] dop, input bit derr);
    idle();
    bus.cmd_valid = 1'b1;
    bus.cmd_we = we;
    bus.cmd_addr = addr;
    bus.cmd_wdata = 32'h1234;
    bus.cmd_mask = mask;
    bus.a_ready = 1'b0;
    cycle();
    chk("lit_a_opcode", 64'(bus.a_opcode), 64'(exp_op));
    chk("lit_a_source", 64'(bus.a_source), 64'(0));
    idle();
    cycle();
    bus.d_valid = 1'b1;
    bus.d_opcode = dop;
    bus.d_error = derr;
    bus.d_data = 32'hDEADBEEF;
    cycle();
    idle();
  endtask
  task automatic rand_inputs();
    int s;
    idle();
    rst = ($urandom_range(0, 299) == 0);
    bus.cmd_valid = ($urandom_range(0, 2) != 0);
    bus.cmd_we = 1'($urandom);
    bus.cmd_addr = $urandom & 32'hFFFF_FFFC;
    bus.cmd_wdata = $urandom;
    bus.cmd_mask = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
    bus.a_ready = ($urandom_range(0, 3) != 0);
    bus.rsp_ready = ($urandom_range(0, 3) != 0);
    if (pend.size() != 0 && $urandom_range(0, 2) != 0) begin
      s = pend[$urandom_range(0, pend.size() - 1)];
      bus.d_valid = 1'b1;
      bus.d_source = SW'(s);
      bus.d_opcode = ($urandom_range(0, 7) == 0) ? 3'd2 : (m_we[s] ? 3'd0 : 3'd1);
      bus.d_error = ($urandom_range(0, 9) == 0);
      bus.d_data = $urandom;
    end else if (m_out != '1 && $urandom_range(0, 40) == 0) begin
      do s = $urandom_range(0, NSRC - 1); while (m_out[s]);
      bus.d_valid = 1'b1;
      bus.d_source = SW'(s);
      bus.d_opcode = 3'd1;
      bus.d_data = $urandom;
    end
  endtask
  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle();
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_d_ready", 64'(bus.d_ready), 64'(1));
    chk("rst_a_valid", 64'(bus.a_valid), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    // read 0x100 answered with AccessAckData
    txn(1'b0, 32'h100, 4'h0, 3'd4, 3'd1, 1'b0);
    chk("rd_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    chk("rd_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
    chk("rd_err", 64'(bus.rsp_err), 64'(0));
    txn(1'b1, 32'h104, 4'h3, 3'd1, 3'd0, 1'b0);
    chk("wr_rdata", 64'(bus.rsp_rdata), 64'(0));
    chk("wr_err", 64'(bus.rsp_err), 64'(0));
    txn(1'b1, 32'h108, 4'hF, 3'd0, 3'd0, 1'b0);
    txn(1'b0, 32'h10C, 4'h0, 3'd4, 3'd1, 1'b1);
    chk("derr_err", 64'(bus.rsp_err), 64'(1));
    txn(1'b1, 32'h110, 4'hF, 3'd0, 3'd1, 1'b0);
    chk("wr_ackdata_err", 64'(bus.rsp_err), 64'(1));
    // A stage held by backpressure
    idle();
    bus.cmd_valid = 1'b1;
    bus.cmd_we = 1'b1;
    bus.cmd_addr = 32'h200;
    bus.cmd_mask = 4'hF;
    bus.a_ready = 1'b0;
    cycle();
    bus.cmd_addr = 32'h300;
    repeat (5) begin
      cycle();
      chk("hold_addr", 64'(bus.a_address), 64'h200);
      chk("hold_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    end
    idle();
    cycle();
    bus.d_valid = 1'b1;
    bus.d_source = 2'd0;
    bus.rsp_ready = 1'b0;
    cycle();
    chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    chk("bp_d_ready", 64'(bus.d_ready), 64'(0));
    idle();
    cycle();
    // unexpected source
    bus.d_valid = 1'b1;
    bus.d_source = 2'd3;
    bus.d_opcode = 3'd1;
    cycle();
    chk("unexp_no_rsp", 64'(bus.rsp_valid), 64'(0));
    chk("unexp_set", 64'(bus.unexp), 64'(1));
    idle();
    repeat (2) cycle();
    chk("unexp_sticky", 64'(bus.unexp), 64'(1));
    // fill all sources, stall, free src2
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = 32'h400;
    repeat (4) cycle();
    chk("full_stall", 64'(bus.cmd_ready), 64'(0));
    bus.d_valid = 1'b1;
    bus.d_source = 2'd2;
    bus.d_opcode = 3'd1;
    cycle();
    bus.d_valid = 1'b0;
    cycle();
    chk("realloc_src2", 64'(bus.a_source), 64'(2));
    chk("realloc_valid", 64'(bus.a_valid), 64'(1));
    // reset mid-operation
    idle();
    rst = 1'b1;
    cycle();
    idle();
    chk("mid_rst_busy", 64'(bus.busy), 64'(0));
    chk("mid_rst_a_valid", 64'(bus.a_valid), 64'(0));
    chk("mid_rst_a_opcode", 64'(bus.a_opcode), 64'(0));
    chk("mid_rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    chk("mid_rst_unexp", 64'(bus.unexp), 64'(0));
    bus.cmd_valid = 1'b1;
    cycle();
    chk("post_rst_src0", 64'(bus.a_source), 64'(0));
    repeat (3000) begin
      rand_inputs();
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
